// File: rtl/adc_avg_fifo.sv
// Detects each new ADC conversion by the rising edge of adc_data_ready and averages
// blocks of 2^LOG2_AVG samples into a small first-word-fall-through FIFO.
module adc_avg_fifo #(
    parameter int DATA_W   = 16,
    parameter int LOG2_AVG = 3,
    parameter int FIFO_AW  = 2
) (
    input  logic              fpga_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_data_ready,
    output logic [DATA_W-1:0] avg_data,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              overflow,
    input  logic              clr_overflow
);
    localparam int N     = 1 << LOG2_AVG;
    localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int ACC_W = DATA_W + LOG2_AVG;
    localparam int PTR_W = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic {
        ACC,
        LAST
    } acc_state_t;

    // With a block length of one every sample completes a block.
    localparam acc_state_t STATE_INIT = (N == 1) ? LAST : ACC;

    logic              rdy_q;
    logic              new_smp;
    logic [DATA_W-1:0] smp_q, smp_d;
    logic              smp_stb_q, smp_stb_d;

    acc_state_t        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push;
    logic [DATA_W-1:0] push_data;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              full;
    logic              pop;
    logic              wr_en;

    logic [DATA_W-1:0] avg_data_q, avg_data_d;
    logic              avg_valid_q, avg_valid_d;
    logic [PTR_W-1:0]  fifo_level_q, fifo_level_d;
    logic              overflow_q, overflow_d;

    always_comb begin
        new_smp   = adc_data_ready & ~rdy_q & enable;
        smp_d     = new_smp ? adc_data : smp_q;
        smp_stb_d = new_smp;
    end

    // Block accumulator; a low enable drops the partial block and any pending strobe.
    always_comb begin
        sum       = acc_q + ACC_W'(smp_q);
        push_data = DATA_W'(sum >> LOG2_AVG);
        push      = 1'b0;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        if (!enable) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (smp_stb_q) begin
            if (state_q == LAST) begin
                push  = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        state_d = (cnt_d == CNT_LAST) ? LAST : ACC;
    end

    // A push into a full FIFO only lands when the head is popped on the same edge.
    always_comb begin
        full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        pop   = avg_valid_q & avg_ready;
        wr_en = push & (~full | pop);

        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[FIFO_AW-1:0]] = push_data;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        avg_data_d   = mem_d[rd_ptr_d[FIFO_AW-1:0]];
        avg_valid_d  = (wr_ptr_d != rd_ptr_d);
        fifo_level_d = wr_ptr_d - rd_ptr_d;

        overflow_d = overflow_q;
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (push & full & ~pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q        <= 1'b0;
            smp_q        <= '0;
            smp_stb_q    <= 1'b0;
            state_q      <= STATE_INIT;
            acc_q        <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            avg_data_q   <= '0;
            avg_valid_q  <= 1'b0;
            fifo_level_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            rdy_q        <= adc_data_ready;
            smp_q        <= smp_d;
            smp_stb_q    <= smp_stb_d;
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            avg_data_q   <= avg_data_d;
            avg_valid_q  <= avg_valid_d;
            fifo_level_q <= fifo_level_d;
            overflow_q   <= overflow_d;
        end
    end

    assign avg_data   = avg_data_q;
    assign avg_valid  = avg_valid_q;
    assign fifo_level = fifo_level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_adc_avg_fifo.sv
// Randomized bench for adc_avg_fifo against a queue-based model of block averaging
// and a bounded FIFO with a sticky drop flag.
module tb_adc_avg_fifo;
    localparam int DATA_W   = 16;
    localparam int LOG2_AVG = 3;
    localparam int FIFO_AW  = 2;
    localparam int N        = 1 << LOG2_AVG;
    localparam int DEPTH    = 1 << FIFO_AW;

    logic              fpga_clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [DATA_W-1:0] adc_data;
    logic              adc_data_ready;
    logic [DATA_W-1:0] avg_data;
    logic              avg_valid;
    logic              avg_ready;
    logic [FIFO_AW:0]  fifo_level;
    logic              overflow;
    logic              clr_overflow;

    int checkCount = 0;
    int errorCount = 0;

    int unsigned blockQ[$];
    int unsigned fifoQ[$];
    bit          ovfModel;
    logic        validAtE1;
    logic        validAtE2;

    adc_avg_fifo #(
        .DATA_W  (DATA_W),
        .LOG2_AVG(LOG2_AVG),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .fpga_clk      (fpga_clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .adc_data      (adc_data),
        .adc_data_ready(adc_data_ready),
        .avg_data      (avg_data),
        .avg_valid     (avg_valid),
        .avg_ready     (avg_ready),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow)
    );

    always #5 fpga_clk = ~fpga_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Model: collect N counted samples, average with plain integer division, queue if room.
    function automatic void modelSample(input int unsigned v);
        int unsigned total;
        blockQ.push_back(v);
        if (blockQ.size() == N) begin
            total = 0;
            foreach (blockQ[i]) total += blockQ[i];
            blockQ.delete();
            if (fifoQ.size() < DEPTH) fifoQ.push_back(total / N);
            else ovfModel = 1'b1;
        end
    endfunction

    function automatic void modelReset();
        blockQ.delete();
        fifoQ.delete();
        ovfModel = 1'b0;
    endfunction

    task automatic checkState(input string tag);
        checkOutput({tag, "_valid"}, avg_valid, fifoQ.size() != 0);
        checkOutput({tag, "_level"}, fifo_level, fifoQ.size());
        checkOutput({tag, "_ovf"}, overflow, ovfModel);
        if (fifoQ.size() != 0) checkOutput({tag, "_data"}, avg_data, fifoQ[0]);
    endtask

    // One conversion: ready high for 'hold' cycles, optional pop/clear on the FIFO write edge.
    task automatic applyStimulus(input logic [DATA_W-1:0] value, input int hold, input int gap,
                                 input bit popAtWrite, input bit clrAtWrite);
        bit counted;
        bit popped;
        counted = enable;
        popped  = 1'b0;
        @(negedge fpga_clk);
        adc_data       = value;
        adc_data_ready = 1'b1;
        @(negedge fpga_clk);
        validAtE1 = avg_valid;
        if (popAtWrite) begin
            avg_ready = 1'b1;
            if (fifoQ.size() != 0) begin
                checkOutput("pop_head", avg_data, fifoQ[0]);
                popped = 1'b1;
            end
        end
        if (clrAtWrite) clr_overflow = 1'b1;
        @(negedge fpga_clk);
        validAtE2    = avg_valid;
        avg_ready    = 1'b0;
        clr_overflow = 1'b0;
        repeat (hold - 2) @(negedge fpga_clk);
        adc_data_ready = 1'b0;
        repeat (gap) @(negedge fpga_clk);
        if (popped) void'(fifoQ.pop_front());
        if (clrAtWrite) ovfModel = 1'b0;
        if (counted) modelSample(value);
    endtask

    task automatic sendSamples(input logic [DATA_W-1:0] value, input int count);
        for (int i = 0; i < count; i++)
            applyStimulus(value, 2 + $urandom_range(0, 2), 1 + $urandom_range(0, 3), 1'b0, 1'b0);
    endtask

    task automatic drainAll(input string tag);
        int n;
        n = fifoQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_drain_valid"}, avg_valid, 1'b1);
            checkOutput({tag, "_drain_data"}, avg_data, fifoQ[0]);
            avg_ready = 1'b1;
            @(negedge fpga_clk);
            avg_ready = 1'b0;
            void'(fifoQ.pop_front());
        end
        checkState({tag, "_empty"});
    endtask

    task automatic clearOverflow();
        @(negedge fpga_clk);
        clr_overflow = 1'b1;
        @(negedge fpga_clk);
        clr_overflow = 1'b0;
        ovfModel = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] basicVals [N];
        basicVals = '{16'd100, 16'd200, 16'd300, 16'd401, 16'd500, 16'd600, 16'd700, 16'd801};

        reset_n        = 1'b0;
        enable         = 1'b0;
        adc_data       = '0;
        adc_data_ready = 1'b0;
        avg_ready      = 1'b0;
        clr_overflow   = 1'b0;
        modelReset();
        repeat (3) @(negedge fpga_clk);
        checkOutput("reset_data", avg_data, 0);
        checkState("reset");
        reset_n = 1'b1;
        @(negedge fpga_clk);
        enable = 1'b1;

        // Basic average: sum 3602 / 8 truncates to 450; output appears two cycles after the edge.
        for (int i = 0; i < N; i++) applyStimulus(basicVals[i], 2, 2, 1'b0, 1'b0);
        checkOutput("basic_lat_e1", validAtE1, 1'b0);
        checkOutput("basic_lat_e2", validAtE2, 1'b1);
        checkOutput("basic_avg", avg_data, 450);
        checkOutput("basic_level", fifo_level, 1);
        checkState("basic");
        drainAll("basic");

        sendSamples(16'hFFFF, N);
        checkOutput("fullscale_max", avg_data, 16'hFFFF);
        sendSamples(16'h0001, N);
        checkState("fullscale");
        drainAll("fullscale");

        for (int i = 0; i < N; i++) applyStimulus(16'h1234, 150, 3, 1'b0, 1'b0);
        checkOutput("held_level", fifo_level, 1);
        checkOutput("held_avg", avg_data, 16'h1234);
        drainAll("held");

        // Overflow: five blocks into a four-deep FIFO, then pop-with-push while full.
        for (int k = 1; k <= 5; k++) sendSamples(DATA_W'(k), N);
        checkOutput("ovf_level", fifo_level, 4);
        checkOutput("ovf_flag", overflow, 1'b1);
        checkState("ovf");
        drainAll("ovf");
        clearOverflow();
        checkOutput("ovf_clr", overflow, 1'b0);
        for (int k = 10; k <= 13; k++) sendSamples(DATA_W'(k), N);
        sendSamples(16'd14, N - 1);
        applyStimulus(16'd14, 2, 2, 1'b1, 1'b0);
        checkOutput("pushpop_level", fifo_level, 4);
        checkOutput("pushpop_ovf", overflow, 1'b0);
        checkState("pushpop");
        drainAll("pushpop");
        for (int k = 20; k <= 24; k++) sendSamples(DATA_W'(k), N);
        sendSamples(16'd25, N - 1);
        applyStimulus(16'd25, 2, 2, 1'b0, 1'b1);
        checkOutput("setwins_ovf", overflow, 1'b1);
        checkState("setwins");
        drainAll("setwins");
        clearOverflow();

        // Enable drop, including a strobe in flight and a level already high at re-enable.
        sendSamples(16'd555, N);
        sendSamples(16'd1000, 3);
        @(negedge fpga_clk);
        adc_data       = 16'd1000;
        adc_data_ready = 1'b1;
        @(negedge fpga_clk);
        enable = 1'b0;
        repeat (2) @(negedge fpga_clk);
        enable = 1'b1;
        repeat (3) @(negedge fpga_clk);
        adc_data_ready = 1'b0;
        repeat (2) @(negedge fpga_clk);
        blockQ.delete();
        sendSamples(16'd40, N);
        checkOutput("enable_level", fifo_level, 2);
        checkOutput("enable_keep", avg_data, 555);
        checkState("enable");
        drainAll("enable");

        sendSamples(16'd900, N);
        sendSamples(16'd3000, 5);
        @(negedge fpga_clk);
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("midreset_data", avg_data, 0);
        checkState("midreset");
        @(negedge fpga_clk);
        reset_n = 1'b1;
        @(negedge fpga_clk);
        sendSamples(16'd7, N);
        checkOutput("postreset_avg", avg_data, 7);
        checkState("postreset");
        drainAll("postreset");

        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 15))
                0: begin
                    @(negedge fpga_clk);
                    enable = 1'b0;
                    @(negedge fpga_clk);
                    enable = 1'b1;
                    blockQ.delete();
                end
                1: drainAll("rnd");
                2: clearOverflow();
                default: ;
            endcase
            applyStimulus(DATA_W'($urandom_range(0, 65535)), $urandom_range(2, 5),
                          $urandom_range(1, 4), $urandom_range(0, 3) == 0, 1'b0);
            checkState("rnd");
        end
        drainAll("final");

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/adc_avg_fifo.md
# adc_avg_fifo

Downstream consumer of the AD7693 serial-read stage. Detects each new conversion result by the rising edge of the reader's level-type `data_ready`, averages blocks of 2^LOG2_AVG consecutive samples, and queues the averaged words in a small first-word-fall-through FIFO. The FIFO drains to the host logic through a valid/ready handshake, and a sticky flag reports any dropped results.

## Interface
- `DATA_W`, 16, sample and average width (unsigned).
- `LOG2_AVG`, 3, log2 of block length N (N = 8); legal range 0..8.
- `FIFO_AW`, 2, FIFO address width; depth = 2^FIFO_AW = 4.

- `fpga_clk`, in, 1, system clock, 100 MHz.
- `reset_n`, in, 1, asynchronous active-low reset.
- `enable`, in, 1, averaging enable.
- `adc_data`, in, DATA_W, sample from the ADC reader.
  - Stable while `adc_data_ready` is high.
- `adc_data_ready`, in, 1, level from the ADC reader.
  - Rises once per conversion and stays high until the next cycle start.
- `avg_data`, out, DATA_W, head-of-FIFO average.
- `avg_valid`, out, 1, FIFO not empty.
- `avg_ready`, in, 1, consumer accepts `avg_data`.
- `fifo_level`, out, FIFO_AW+1, number of stored entries (0..4).
- `overflow`, out, 1, sticky; set when an average is dropped.
- `clr_overflow`, in, 1, synchronous clear of `overflow`.

## Operation
- **Reset values:**
  - `avg_valid`=0, `avg_data`=0, `fifo_level`=0, `overflow`=0.
  - Accumulator=0, sample count=0, FIFO pointers=0, edge-detect register=0.
- **Edge detect:**
  - `rdy_d` is a registered copy of `adc_data_ready`.
  - `new_smp` = `adc_data_ready` & ~`rdy_d` & `enable`.
  - A level held high for any duration counts as exactly one sample.
- **Capture stage:**
  - On `new_smp`, register `adc_data` into `smp_r` and set strobe `smp_stb` for one cycle.
- **Accumulate stage:**
  - State machine `ACC` / `LAST`, driven by the count `cnt` (LOG2_AVG bits; ACC when cnt < N-1).
  - On `smp_stb` with cnt < N-1: `acc` += `smp_r`, `cnt`++.
  - On `smp_stb` with cnt == N-1:
    - result = (`acc` + `smp_r`) >> LOG2_AVG, truncated, no rounding.
    - Write the result to the FIFO.
    - `acc` ← 0, `cnt` ← 0.
- **Width rules:**
  - `acc` is DATA_W+LOG2_AVG bits and never wraps.
  - An all-ones input yields an all-ones average.
  - LOG2_AVG=0 passes each sample straight through.
- **Enable:**
  - `enable` low blocks `new_smp`.
  - A pending `smp_stb` is discarded, and `acc`/`cnt` clear on the next clock.
  - The partial block is lost; FIFO contents and `overflow` are kept.
  - Re-enabling starts a fresh block.
  - A `adc_data_ready` that is already high when `enable` rises is not counted; `rdy_d` tracks regardless of `enable`.
- **FIFO:**
  - Write and read pointers are FIFO_AW+1 bits.
  - Full when pointers differ only in the MSB; empty when equal.
  - `avg_data` always shows the head entry (first-word-fall-through).
  - Pop occurs when `avg_valid` & `avg_ready`.
- **Write while full without a simultaneous pop:** the result is dropped, `overflow` ← 1, and the stored entries are unchanged.
- **Simultaneous write and pop when full:** both succeed, `fifo_level` stays at 4, no overflow.
- **Simultaneous write and pop when empty:** not possible; `avg_valid` is 0 on that cycle. The new entry appears on the next cycle.
- **`clr_overflow` coinciding with a new drop:** set wins, and `overflow` stays 1.
- **Reset asserted mid-block or mid-transfer:** all state returns to the reset values immediately. The partial block and FIFO contents are lost.

## Timing
- Let E be the first cycle in which `adc_data_ready`=1 and `rdy_d`=0, with `enable`=1.
  - Clock edge ending E: `smp_r` is loaded and `smp_stb`=1 during E+1.
  - Clock edge ending E+1: the accumulator updates, or the FIFO is written for the Nth sample.
  - `avg_valid` and the new `fifo_level` are visible from cycle E+2.
- **Latency:** 2 cycles from the detected edge to the average at the FIFO output (FIFO empty).
- **Pop:** when `avg_valid` & `avg_ready` at a clock edge, the next entry (or `avg_valid`=0) appears on the following cycle.
- **Throughput:** one sample per ≥2 cycles is guaranteed. The ADC delivers one per 200 cycles (2 µs).
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Basic average:** LOG2_AVG=2, samples 100, 200, 300, 401 on four `adc_data_ready` pulses -> `avg_data`=250, `avg_valid` high 2 cycles after the 4th edge, `fifo_level`=1.
- **Full scale:** LOG2_AVG=3, eight samples of 0xFFFF -> `avg_data`=0xFFFF. Eight samples of 0x0001 -> 0x0001.
- **Level held:** `adc_data_ready` held high for 150 cycles per sample, 8 samples of 0x1234 -> exactly one average, 0x1234. A single held level counts once.
- **Overflow:** `avg_ready`=0 and 5 blocks with averages 1..5.
  - Required: `fifo_level`=4, `overflow`=1, then drain yields 1, 2, 3, 4.
  - `clr_overflow` -> `overflow`=0.
  - Repeat with pop and push in the same cycle while full -> no overflow.
- **Enable drop:** 3 samples of 1000, `enable` low, `enable` high, 8 samples of 40 -> single average 40. The earlier FIFO entry is retained.
- **Reset mid-block:** 5 samples, `reset_n` pulsed low -> all outputs 0. The next 8 samples of 7 -> average 7.
